// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM general-purpose I/O slave:
// register word addresses, edge-capture modes and the bus address type.
package avalon_pio_pkg;

  typedef logic [2:0] addr_t;

  localparam addr_t ADDR_DATA    = 3'd0;
  localparam addr_t ADDR_DIR     = 3'd1;
  localparam addr_t ADDR_IRQMASK = 3'd2;
  localparam addr_t ADDR_EDGECAP = 3'd3;
  localparam addr_t ADDR_OUTSET  = 3'd4;
  localparam addr_t ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_gen2_if.sv
// Avalon-MM slave bus bundle for the PIO: address, chipselect, write_n,
// writedata (master drives) and zero-wait-state readdata (slave drives).
interface avalon_pio_gen2_if;
  import avalon_pio_pkg::*;

  addr_t       address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain, delay flop, warm-up counter and edge term.
// Ports: clk, reset_n, pio_in (async pins), sync_in, edge_det.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int DATA_WIDTH  = 14,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] pio_in,
  output logic [DATA_WIDTH-1:0] sync_in,
  output logic [DATA_WIDTH-1:0] edge_det
);

  localparam int CW = 3;
  localparam logic [CW-1:0] WARM = CW'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] sq [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] prev;
  logic [DATA_WIDTH-1:0] raw;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sq[i] <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      sq[0] <= pio_in;
      for (int i = 1; i < SYNC_STAGES; i++)
        sq[i] <= sq[i-1];
      prev <= sq[SYNC_STAGES-1];
      if (cnt != WARM)
        cnt <= cnt + 1'b1;
    end
  end

  assign sync_in = sq[SYNC_STAGES-1];

  generate
    if (EDGE_TYPE == EDGE_FALL) begin : g_fall
      assign raw = ~sync_in & prev;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
      assign raw = sync_in ^ prev;
    end else begin : g_rise
      assign raw = sync_in & ~prev;
    end
  endgenerate

  // Chain resets to 0, so pins already high at reset would look like
  // a rising edge; hold detection off until the chain has filled.
  assign edge_det = (cnt == WARM) ? raw : '0;

endmodule

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM PIO slave: data/dir/mask/edgecap registers, set/clear, irq.
// Ports: clk, reset_n, bus (slave), pio_in, pio_out, pio_oe, irq.
module avalon_pio_gen2
  import avalon_pio_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 14,
  parameter logic [DATA_WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR   = '1,
  parameter int                    EDGE_TYPE   = EDGE_RISE,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_gen2_if.slave      bus,
  input  logic [DATA_WIDTH-1:0] pio_in,
  output logic [DATA_WIDTH-1:0] pio_out,
  output logic [DATA_WIDTH-1:0] pio_oe,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out;
  logic [DATA_WIDTH-1:0] dir;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] edge_det;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] ec_clr;
  logic [DATA_WIDTH-1:0] rd;
  logic                  wr;
  logic                  unused_wd;

  pio_sync_edge #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .pio_in   (pio_in),
    .sync_in  (sync_in),
    .edge_det (edge_det)
  );

  assign wr        = bus.chipselect & ~bus.write_n;
  assign wd        = bus.writedata[DATA_WIDTH-1:0];
  assign unused_wd = ^bus.writedata;

  assign ec_clr =
    (wr && bus.address == ADDR_EDGECAP) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      mask     <= '0;
      edgecap  <= '0;
    end else begin
      if (wr) begin
        case (bus.address)
          ADDR_DATA:    data_out <= wd;
          ADDR_DIR:     dir      <= wd;
          ADDR_IRQMASK: mask     <= wd;
          ADDR_OUTSET:  data_out <= data_out | wd;
          ADDR_OUTCLR:  data_out <= data_out & ~wd;
          default: ;
        endcase
      end
      // A fresh edge overrides a same-cycle write-1-to-clear.
      edgecap <= (edgecap & ~ec_clr) | edge_det;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.address)
      ADDR_DATA:    rd = (sync_in & ~dir) | (data_out & dir);
      ADDR_DIR:     rd = dir;
      ADDR_IRQMASK: rd = mask;
      ADDR_EDGECAP: rd = edgecap;
      default:      rd = '0;
    endcase
  end

  assign bus.readdata = 32'(rd);

  assign pio_out = data_out;
  assign pio_oe  = dir;
  assign irq     = |(edgecap & mask);

endmodule

// File: tb/tb_avalon_pio_gen2.sv
// Self-checking bench for avalon_pio_gen2 with a pin-history
// reference model; directed scenarios plus a randomized run.
module tb_avalon_pio_gen2;
  import avalon_pio_pkg::*;

  localparam int W = 14;
  localparam int S = 2;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] pio_in;
  logic [W-1:0] pio_out;
  logic [W-1:0] pio_oe;
  logic         irq;

  int tests;
  int fails;

  avalon_pio_gen2_if bus();

  avalon_pio_gen2 #(
    .DATA_WIDTH  (W),
    .RESET_OUT   (14'h0000),
    .RESET_DIR   (14'h3FFF),
    .EDGE_TYPE   (EDGE_RISE),
    .SYNC_STAGES (S)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .pio_in  (pio_in),
    .pio_out (pio_out),
    .pio_oe  (pio_oe),
    .irq     (irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model: ph[k] is the pin value sampled k edges ago.
  logic [W-1:0] m_out, m_dir, m_mask, m_ec;
  logic [W-1:0] ph[$];
  int           m_cyc;

  function automatic logic [W-1:0] pget(int i);
    if (i < ph.size()) return ph[i];
    return '0;
  endfunction

  function automatic logic [31:0] mread(logic [2:0] a);
    logic [W-1:0] s;
    s = pget(S - 1);
    case (a)
      3'd0:    return {18'b0, (s & ~m_dir) | (m_out & m_dir)};
      3'd1:    return {18'b0, m_dir};
      3'd2:    return {18'b0, m_mask};
      3'd3:    return {18'b0, m_ec};
      default: return 32'b0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin : mdl
    logic [W-1:0] s, p, e, wd;
    if (!reset_n) begin
      m_out  = '0;
      m_dir  = '1;
      m_mask = '0;
      m_ec   = '0;
      ph.delete();
      m_cyc  = 0;
    end else begin
      s  = pget(S - 1);
      p  = pget(S);
      e  = s & ~p;
      if (m_cyc < S + 1) e = '0;
      wd = bus.writedata[W-1:0];
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          3'd0: m_out  = wd;
          3'd1: m_dir  = wd;
          3'd2: m_mask = wd;
          3'd3: m_ec   = m_ec & ~wd;
          3'd4: m_out  = m_out | wd;
          3'd5: m_out  = m_out & ~wd;
          default: ;
        endcase
      end
      m_ec = m_ec | e;
      ph.push_front(pio_in);
      if (ph.size() > 8) void'(ph.pop_back());
      if (m_cyc < 1000) m_cyc++;
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n        = 1'b0;
    pio_in         = 14'h3FFF;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    tests++;
    if (pio_out !== 14'h0000) begin
      fails++;
      $display("FAIL reset_out: got %h want 0000", pio_out);
    end
    tests++;
    if (pio_oe !== 14'h3FFF) begin
      fails++;
      $display("FAIL reset_oe: got %h want 3fff", pio_oe);
    end
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
    bus_read(ADDR_EDGECAP, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL reset_ec: got %h want 0", d);
    end
    repeat (20) @(posedge clk);
    bus_read(ADDR_EDGECAP, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL warmup_ec: got %h want 0", d);
    end
  endtask

  task automatic test_set_clear();
    logic [31:0] d;
    bus_write(ADDR_DATA, 32'hFFFF_0F0F);
    tests++;
    if (pio_out !== 14'h0F0F) begin
      fails++;
      $display("FAIL data_wr: got %h want 0f0f", pio_out);
    end
    @(negedge clk);
    tests++;
    if (pio_out !== 14'h0F0F) begin
      fails++;
      $display("FAIL data_hold: got %h want 0f0f", pio_out);
    end
    bus_write(ADDR_OUTSET, 32'h0000_3000);
    tests++;
    if (pio_out !== 14'h3F0F) begin
      fails++;
      $display("FAIL outset: got %h want 3f0f", pio_out);
    end
    bus_write(ADDR_OUTCLR, 32'h0000_000F);
    tests++;
    if (pio_out !== 14'h3F00) begin
      fails++;
      $display("FAIL outclr: got %h want 3f00", pio_out);
    end
    bus_read(ADDR_OUTSET, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL outset_rd: got %h want 0", d);
    end
    bus_read(ADDR_OUTCLR, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL outclr_rd: got %h want 0", d);
    end
  endtask

  task automatic test_dir_readback();
    logic [31:0] d;
    bus_write(ADDR_DIR, 32'h0000_00FF);
    bus_write(ADDR_DATA, 32'h0000_1234);
    @(negedge clk);
    pio_in = 14'h3C00;
    repeat (2) @(posedge clk);
    bus_read(ADDR_DATA, d);
    tests++;
    if (d !== 32'h0000_3C34) begin
      fails++;
      $display("FAIL dir_rd: got %h want 00003c34", d);
    end
    tests++;
    if (d[31:14] !== 18'h0) begin
      fails++;
      $display("FAIL rd_upper: got %h want 0", d[31:14]);
    end
    bus_read(ADDR_DIR, d);
    tests++;
    if (d !== 32'h0000_00FF) begin
      fails++;
      $display("FAIL dir_reg: got %h want 000000ff", d);
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    @(negedge clk);
    pio_in = '0;
    repeat (4) @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'h3FFF);
    bus_write(ADDR_IRQMASK, 32'h0001);
    @(negedge clk);
    pio_in[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_early: got %b want 0", irq);
    end
    @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_n2: got %b want 1", irq);
    end
    bus_read(ADDR_EDGECAP, d);
    tests++;
    if (d !== 32'h0001) begin
      fails++;
      $display("FAIL ec_n2: got %h want 1", d);
    end
    bus_write(ADDR_EDGECAP, 32'h0001);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_clr: got %b want 0", irq);
    end
    bus_read(ADDR_EDGECAP, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL ec_clr: got %h want 0", d);
    end
    bus_write(ADDR_IRQMASK, 32'h0);
    @(negedge clk);
    pio_in[0] = 1'b0;
    repeat (4) @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'h3FFF);
    @(negedge clk);
    pio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_masked: got %b want 0", irq);
    end
    bus_write(ADDR_IRQMASK, 32'h0001);
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_unmask: got %b want 1", irq);
    end
    bus_write(ADDR_IRQMASK, 32'h0);
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_remask: got %b want 0", irq);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    @(negedge clk);
    pio_in = '0;
    repeat (4) @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'h3FFF);
    @(negedge clk);
    pio_in[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.address    = ADDR_EDGECAP;
    bus.writedata  = 32'h0008;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus_read(ADDR_EDGECAP, d);
    tests++;
    if (d !== 32'h0008) begin
      fails++;
      $display("FAIL collide: got %h want 8", d);
    end
    bus_write(ADDR_EDGECAP, 32'h0008);
    @(negedge clk);
    pio_in[3] = 1'b0;
    repeat (5) @(posedge clk);
    bus_read(ADDR_EDGECAP, d);
    tests++;
    if (d !== 32'h0) begin
      fails++;
      $display("FAIL fall_nocap: got %h want 0", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(3) == 0) pio_in = W'($urandom);
      bus.chipselect = 1'($urandom_range(1));
      bus.write_n    = 1'($urandom_range(1));
      bus.address    = 3'($urandom_range(7));
      bus.writedata  = $urandom;
      @(posedge clk);
      #1;
      exp = mread(bus.address);
      tests++;
      if (pio_out !== m_out || pio_oe !== m_dir) begin
        fails++;
        $display("FAIL rnd_out %0d: got %h/%h want %h/%h",
                 i, pio_out, pio_oe, m_out, m_dir);
      end
      tests++;
      if (irq !== |(m_ec & m_mask)) begin
        fails++;
        $display("FAIL rnd_irq %0d: got %b want %b",
                 i, irq, |(m_ec & m_mask));
      end
      tests++;
      if (bus.readdata !== exp) begin
        fails++;
        $display("FAIL rnd_rd %0d a=%0d: got %h want %h",
                 i, bus.address, bus.readdata, exp);
      end
    end
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pio_in = '0;
    repeat (4) @(posedge clk);
    bus_write(ADDR_EDGECAP, 32'h3FFF);
    bus_write(ADDR_DATA, 32'h3FFF);
    bus_write(ADDR_IRQMASK, 32'h0001);
    @(negedge clk);
    pio_in[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (irq !== 1'b1 || pio_out !== 14'h3FFF) begin
      fails++;
      $display("FAIL pre_rst: got irq=%b out=%h want 1/3fff",
               irq, pio_out);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (pio_out !== 14'h0000 || irq !== 1'b0) begin
      fails++;
      $display("FAIL async_rst: got out=%h irq=%b want 0000/0",
               pio_out, irq);
    end
    tests++;
    if (pio_oe !== 14'h3FFF) begin
      fails++;
      $display("FAIL async_oe: got %h want 3fff", pio_oe);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_set_clear();
    test_dir_readback();
    test_rise_irq();
    test_collision();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_pio_gen2.md
Name: avalon_pio_gen2

Overview:
- Parametrised general-purpose I/O slave for the NIOS II Avalon-MM system bus.
- Supersedes the fixed-width output-only LED PIO.
- Adds:
  - configurable width and per-bit direction
  - atomic output set/clear
  - synchronised inputs with edge capture
  - maskable level interrupt to the CPU
- Sits between the Avalon interconnect and board LEDs/switches/keys.

Parameters:
- DATA_WIDTH, 14, number of PIO bits (1..32).
- RESET_OUT, 0, reset value of the output data register (DATA_WIDTH bits).
- RESET_DIR, all ones, reset value of the direction register (1 = output).
- EDGE_TYPE, 0, capture mode: 0 rising, 1 falling, 2 any edge.
- SYNC_STAGES, 2, input synchroniser depth (2..4).

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 3, Avalon word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data. Zero wait states; combinational from address; bits above DATA_WIDTH read 0.
- pio_in, input, DATA_WIDTH, asynchronous pin inputs.
- pio_out, output, DATA_WIDTH, output data register.
- pio_oe, output, DATA_WIDTH, direction register (1 = drive).
- irq, output, 1, level interrupt.

Behaviour:
- Reset is asynchronous (reset_n low). All registers are cleared, except:
  - data_out resets to RESET_OUT.
  - dir resets to RESET_DIR.
  - After reset: irq = 0, edgecap = 0, mask = 0, warm-up counter = 0.
- Write strobe: wr = chipselect & ~write_n. Only the low DATA_WIDTH bits of writedata are used.
- Register map (address: read / write):
  - 0 DATA: read `(sync_in & ~dir) | (data_out & dir)`; write `data_out <= wd`.
  - 1 DIR: read/write dir.
  - 2 IRQMASK: read/write mask.
  - 3 EDGECAP: read edgecap; write-1-to-clear, bits written 0 are unchanged.
  - 4 OUTSET: read 0; write `data_out <= data_out | wd`.
  - 5 OUTCLR: read 0; write `data_out <= data_out & ~wd`.
  - 6, 7: read 0; writes ignored.
- Register writes take effect at the clk edge where wr is sampled. pio_out updates the same edge.
- Input path:
  - pio_in passes through SYNC_STAGES flops (sync_in = last stage), then one delay flop (prev).
  - Edge term per bit:
    - EDGE_TYPE 0 (rising): `sync_in & ~prev`
    - EDGE_TYPE 1 (falling): `~sync_in & prev`
    - EDGE_TYPE 2 (any): `sync_in ^ prev`
- Latency: a pin change first sampled at edge N
  - appears in sync_in after edge N+SYNC_STAGES-1
  - sets edgecap at edge N+SYNC_STAGES
  - raises irq in that same cycle.
- Warm-up: a saturating counter runs from reset release. Edge detection is suppressed until SYNC_STAGES+1 clocks have elapsed. This prevents spurious captures of pins already high at reset.
- Simultaneous events on one bit:
  - Edge detected and EDGECAP write-1-clear in the same cycle: the bit stays 1 (edge wins).
  - Edge on a bit already set: no change.
- irq = |(edgecap & mask). It is combinational from registers, so no glitch from the bus path.
  - Masking a pending bit drops irq the next cycle.
  - Unmasking a pending bit raises irq the next cycle.
- Edge capture runs regardless of dir.
- An Avalon read has no side effects.

Decomposition:
- Package avalon_pio_pkg holds:
  - address constants: ADDR_DATA = 0, ADDR_DIR = 1, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3, ADDR_OUTSET = 4, ADDR_OUTCLR = 5.
  - edge-type constants: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module pio_sync_edge: synchroniser chain, prev flop, warm-up counter and edge term. Parametrised by DATA_WIDTH, SYNC_STAGES, EDGE_TYPE.
- The top level holds the register file, the read mux and irq.

Test Plan:
1. Reset check: hold reset_n low, release. Required: pio_out = 14'h0000, pio_oe = 14'h3FFF, irq = 0, edgecap = 0. With pio_in = 14'h3FFF held through reset, EDGECAP still reads 0 twenty cycles later.
2. Set/clear: write DATA 14'h0F0F, OUTSET 14'h3000, OUTCLR 14'h000F. Required: pio_out steps 14'h0F0F → 14'h3F0F → 14'h3F00, each change on the write edge; OUTSET and OUTCLR read 0.
3. Direction readback: write DIR 14'h00FF, DATA 14'h1234, drive pio_in = 14'h3C00. Required: DATA read after 2 clocks = 14'h3C34; readdata[31:14] = 0.
4. Rising capture and irq: IRQMASK = 14'h0001; pin 0 goes 0→1 sampled at edge N. Required: EDGECAP = 14'h0001 and irq = 1 at N+2. Write EDGECAP 14'h0001: next cycle EDGECAP = 0, irq = 0.
5. Collision: a pin 3 rising edge lands in the same cycle as an EDGECAP write of 14'h0008. Required: bit 3 remains 1. A falling edge with EDGE_TYPE = 0 produces no capture.
6. Async reset mid-operation: assert reset_n low between clocks with data_out = 14'h3FFF and irq = 1. Required: pio_out = RESET_OUT and irq = 0 immediately, without waiting for a clk edge.
